// File: rtl/kws_frame_scheduler.sv
// kws_frame_scheduler: buffers MFCC words from the front end, feeds them to
// the keyword accelerator one frame at a time, samples the accelerator result
// after a fixed latency and confirms keywords over consecutive frames.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for enable with at least one full frame buffered
// FEED   | popping one word per cycle into the accelerator
// WAIT   | accelerator latency, nothing driven
// SAMPLE | result captured on the closing edge, streak updated
module kws_frame_scheduler #(
    parameter int INPUT_WIDTH = 32,
    parameter int OUTPUT_SIZE = 2,
    parameter int FRAME_LEN   = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int RESULT_LAT  = 2,
    parameter int CONFIRM_CNT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [INPUT_WIDTH-1:0] mfcc_in,
    input  logic                   mfcc_in_valid,
    output logic                   mfcc_in_ready,
    output logic [INPUT_WIDTH-1:0] acc_mfcc,
    output logic                   acc_mfcc_valid,
    input  logic                   keyword_detected,
    input  logic [OUTPUT_SIZE-1:0] keyword_class,
    output logic                   kw_event,
    output logic [OUTPUT_SIZE-1:0] kw_class,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam int WW = $clog2(RESULT_LAT + 2);
    localparam int SW = $clog2(CONFIRM_CNT + 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, SAMPLE} state_t;

    state_t                 state;
    logic [INPUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [FW-1:0]          feed_left;
    logic [WW-1:0]          wait_left;
    logic [SW-1:0]          streak;
    logic [SW-1:0]          streak_next;
    logic [OUTPUT_SIZE-1:0] last_class;
    logic                   push;
    logic                   pop;
    logic                   start;

    assign mfcc_in_ready = (count < CW'(FIFO_DEPTH));
    assign push          = mfcc_in_valid && mfcc_in_ready;
    // A frame only starts with FRAME_LEN words present and the pops during
    // FEED never exceed that, so the FIFO is never read while empty.
    assign start         = (state == IDLE) && enable && (count >= CW'(FRAME_LEN));
    assign pop           = !flush && (start || ((state == FEED) && (feed_left != '0)));
    assign busy          = (state != IDLE);

    // Buffer storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= mfcc_in;
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Streak the sampled result would produce.
    always_comb begin
        streak_next = streak;
        if (keyword_detected) begin
            if (keyword_class == last_class) begin
                streak_next = (streak == SW'(CONFIRM_CNT)) ? streak : streak + SW'(1);
            end else begin
                streak_next = SW'(1);
            end
        end else begin
            streak_next = '0;
        end
    end

    // Frame sequencing, accelerator feed and keyword confirmation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            feed_left      <= '0;
            wait_left      <= '0;
            acc_mfcc       <= '0;
            acc_mfcc_valid <= 1'b0;
            streak         <= '0;
            last_class     <= '0;
            kw_event       <= 1'b0;
            kw_class       <= '0;
            frame_cnt      <= '0;
        end else begin
            kw_event <= 1'b0;
            if (flush) begin
                state          <= IDLE;
                feed_left      <= '0;
                wait_left      <= '0;
                acc_mfcc_valid <= 1'b0;
                streak         <= '0;
                last_class     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        acc_mfcc_valid <= 1'b0;
                        if (start) begin
                            acc_mfcc       <= mem[rd_ptr];
                            acc_mfcc_valid <= 1'b1;
                            feed_left      <= FW'(FRAME_LEN - 1);
                            state          <= FEED;
                        end
                    end
                    FEED: begin
                        if (feed_left != '0) begin
                            acc_mfcc       <= mem[rd_ptr];
                            acc_mfcc_valid <= 1'b1;
                            feed_left      <= feed_left - FW'(1);
                        end else begin
                            acc_mfcc_valid <= 1'b0;
                            if (RESULT_LAT == 0) begin
                                state <= SAMPLE;
                            end else begin
                                wait_left <= WW'(RESULT_LAT - 1);
                                state     <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        acc_mfcc_valid <= 1'b0;
                        if (wait_left == '0) begin
                            state <= SAMPLE;
                        end else begin
                            wait_left <= wait_left - WW'(1);
                        end
                    end
                    SAMPLE: begin
                        acc_mfcc_valid <= 1'b0;
                        frame_cnt      <= frame_cnt + 16'd1;
                        streak         <= streak_next;
                        if (keyword_detected) begin
                            last_class <= keyword_class;
                        end
                        // A class change restarts the streak, so it counts as
                        // a fresh arrival at the threshold.
                        if ((streak_next == SW'(CONFIRM_CNT)) &&
                            ((streak != SW'(CONFIRM_CNT)) || (keyword_class != last_class))) begin
                            kw_event <= 1'b1;
                            kw_class <= keyword_class;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
